// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side bundle for the operand-hazard scoreboard.
// master = decode/pipeline control side, slave = the scoreboard itself.
interface hazard_scoreboard_if #(
  parameter int NSTAGES = 3,
  parameter int NSRC    = 2,
  parameter int SELW    = $clog2(NSTAGES + 1)
);
  logic                   hold;
  logic                   flush;
  logic                   issue_valid;
  logic                   issue_we;
  logic [4:0]             issue_dst;
  logic [SELW-1:0]        issue_lat;
  logic [NSRC*5-1:0]      src_addr;
  logic [NSRC-1:0]        src_used;
  logic                   stall;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic [SELW-1:0]        inflight;

  modport master (
    output hold, flush, issue_valid, issue_we, issue_dst, issue_lat,
           src_addr, src_used,
    input  stall, fwd_sel, inflight
  );

  modport slave (
    input  hold, flush, issue_valid, issue_we, issue_dst, issue_lat,
           src_addr, src_used,
    output stall, fwd_sel, inflight
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes in stages S1..SN after
// decode and gives decode a stall request plus a per-source forward select.
// Build option: SCOREBOARD_FWD_EN enables forwarding; without it the unit is
// a full interlock (any in-flight producer stalls, fwd_sel is always 0).
// The interface instance must be built with the same NSTAGES/NSRC/SELW.
module hazard_scoreboard #(
  parameter int NSTAGES = 3,
  parameter int NSRC    = 2,
  parameter int SELW    = $clog2(NSTAGES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave sb
);

  // Slot k (0-based) holds the instruction in stage S(k+1).
  logic [NSTAGES-1:0]   slot_v_r;
  logic [NSTAGES-1:0]   slot_v_nxt_s;
  logic [4:0]           slot_dst_r     [NSTAGES];
  logic [4:0]           slot_dst_nxt_s [NSTAGES];
  logic [SELW-1:0]      inflight_r;

  logic                 new_v_s;
  logic [NSRC-1:0]      src_live_s;
  logic [NSRC-1:0]      src_hit_s;
  logic [NSRC-1:0]      src_stall_s;
  logic                 stall_s;
  logic [NSRC*SELW-1:0] fwd_sel_s;

`ifdef SCOREBOARD_FWD_EN
  localparam logic [SELW-1:0] LAT_MIN = SELW'(1);
  localparam logic [SELW-1:0] LAT_MAX = SELW'(NSTAGES);

  logic [SELW-1:0] slot_lat_r     [NSTAGES];
  logic [SELW-1:0] slot_lat_nxt_s [NSTAGES];
  logic [SELW-1:0] new_lat_s;
  logic [SELW-1:0] src_hit_k_s    [NSRC];
  logic [SELW-1:0] src_hit_lat_s  [NSRC];

  // A latency of 0 means "ALU-like"; anything past the last stage is capped.
  function automatic logic [SELW-1:0] clamp_lat(input logic [SELW-1:0] lat);
    logic [SELW-1:0] res;
    if (lat == {SELW{1'b0}}) begin
      res = LAT_MIN;
    end else if (lat > LAT_MAX) begin
      res = LAT_MAX;
    end else begin
      res = lat;
    end
    return res;
  endfunction

  assign new_lat_s = clamp_lat(sb.issue_lat);
`else
  // Latency only matters when forwarding; interlock stalls on any match.
  logic lat_unused_s;
  assign lat_unused_s = ^sb.issue_lat;
`endif

  // Number of set bits in the slot-valid vector.
  function automatic logic [SELW-1:0] count_valid(input logic [NSTAGES-1:0] v);
    logic [SELW-1:0] cnt;
    cnt = {SELW{1'b0}};
    for (int k = 0; k < NSTAGES; k++) begin
      cnt = cnt + SELW'(v[k]);
    end
    return cnt;
  endfunction

  // Writes to $0 or non-writing instructions never occupy a slot.
  assign new_v_s = sb.issue_valid & sb.issue_we & (sb.issue_dst != 5'd0);

  // Youngest-producer search per source: scan oldest to youngest, last hit wins.
  always_comb begin
    src_live_s = '0;
    src_hit_s  = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_live_s[i] = sb.src_used[i] & (sb.src_addr[5*i +: 5] != 5'd0);
`ifdef SCOREBOARD_FWD_EN
      src_hit_k_s[i]   = {SELW{1'b0}};
      src_hit_lat_s[i] = {SELW{1'b0}};
`endif
      for (int k = NSTAGES - 1; k >= 0; k--) begin
        if (src_live_s[i] && slot_v_r[k] && (slot_dst_r[k] == sb.src_addr[5*i +: 5])) begin
          src_hit_s[i]     = 1'b1;
`ifdef SCOREBOARD_FWD_EN
          src_hit_k_s[i]   = SELW'(k + 1);
          src_hit_lat_s[i] = slot_lat_r[k];
`endif
        end else begin
          src_hit_s[i] = src_hit_s[i];
        end
      end
    end
  end

  // Turn each source match into either a forward select or a stall request.
  always_comb begin
    src_stall_s = '0;
    fwd_sel_s   = '0;
    for (int i = 0; i < NSRC; i++) begin
`ifdef SCOREBOARD_FWD_EN
      if (src_hit_s[i] && (src_hit_k_s[i] < src_hit_lat_s[i])) begin
        src_stall_s[i] = 1'b1;
      end else if (src_hit_s[i]) begin
        fwd_sel_s[i*SELW +: SELW] = src_hit_k_s[i];
      end else begin
        src_stall_s[i] = 1'b0;
      end
`else
      src_stall_s[i] = src_hit_s[i];
`endif
    end
  end

  assign stall_s = sb.issue_valid & (|src_stall_s);

  // Next slot contents: freeze on hold, bubble on flush/stall, else shift in.
  always_comb begin
    slot_v_nxt_s   = slot_v_r;
    slot_dst_nxt_s = slot_dst_r;
`ifdef SCOREBOARD_FWD_EN
    slot_lat_nxt_s = slot_lat_r;
`endif
    if (sb.hold) begin
      if (sb.flush) begin
        slot_v_nxt_s[0] = 1'b0;
      end else begin
        slot_v_nxt_s[0] = slot_v_r[0];
      end
    end else begin
      for (int k = 1; k < NSTAGES; k++) begin
        slot_v_nxt_s[k]   = slot_v_r[k-1];
        slot_dst_nxt_s[k] = slot_dst_r[k-1];
`ifdef SCOREBOARD_FWD_EN
        slot_lat_nxt_s[k] = slot_lat_r[k-1];
`endif
      end
      if (sb.flush || stall_s) begin
        slot_v_nxt_s[0]   = 1'b0;
        slot_dst_nxt_s[0] = 5'd0;
`ifdef SCOREBOARD_FWD_EN
        slot_lat_nxt_s[0] = {SELW{1'b0}};
`endif
      end else begin
        slot_v_nxt_s[0]   = new_v_s;
        slot_dst_nxt_s[0] = sb.issue_dst;
`ifdef SCOREBOARD_FWD_EN
        slot_lat_nxt_s[0] = new_lat_s;
`endif
      end
    end
  end

  // Slot state and occupancy count; reset empties every slot at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_v_r   <= '0;
      inflight_r <= {SELW{1'b0}};
      for (int k = 0; k < NSTAGES; k++) begin
        slot_dst_r[k] <= 5'd0;
`ifdef SCOREBOARD_FWD_EN
        slot_lat_r[k] <= {SELW{1'b0}};
`endif
      end
    end else begin
      slot_v_r   <= slot_v_nxt_s;
      slot_dst_r <= slot_dst_nxt_s;
`ifdef SCOREBOARD_FWD_EN
      slot_lat_r <= slot_lat_nxt_s;
`endif
      inflight_r <= count_valid(slot_v_nxt_s);
    end
  end

  assign sb.stall    = stall_s;
  assign sb.fwd_sel  = fwd_sel_s;
  assign sb.inflight = inflight_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed, table-driven bench for hazard_scoreboard
// (NSTAGES=3, NSRC=2). Expected values follow the build option
// SCOREBOARD_FWD_EN (forwarding) or its absence (full interlock).
module tb_hazard_scoreboard;

  localparam int NSTAGES = 3;
  localparam int NSRC    = 2;
  localparam int SELW    = 2;

  logic clk;
  logic rst;

  hazard_scoreboard_if #(.NSTAGES(NSTAGES), .NSRC(NSRC), .SELW(SELW)) sb_if ();

  hazard_scoreboard #(.NSTAGES(NSTAGES), .NSRC(NSRC), .SELW(SELW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  typedef struct {
    logic       hold;
    logic       flush;
    logic       iv;
    logic       we;
    logic [4:0] dst;
    logic [1:0] lat;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] used;
    logic       e_stall;
    logic [3:0] e_fwd;   // {fwd_sel src1, fwd_sel src0}
    logic [1:0] e_inf;   // inflight after the edge
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic h, input logic f, input logic iv, input logic we,
                     input logic [4:0] dst, input logic [1:0] lat,
                     input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                     input logic es, input logic [3:0] ef, input logic [1:0] ei);
    vec_t v;
    v.hold = h; v.flush = f; v.iv = iv; v.we = we; v.dst = dst; v.lat = lat;
    v.s0 = s0; v.s1 = s1; v.used = used; v.e_stall = es; v.e_fwd = ef; v.e_inf = ei;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [1:0] ei);
    add(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00, 1'b0, 4'h0, ei);
  endtask

  task automatic drive(input logic h, input logic f, input logic iv, input logic we,
                       input logic [4:0] dst, input logic [1:0] lat,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    sb_if.hold        = h;
    sb_if.flush       = f;
    sb_if.issue_valid = iv;
    sb_if.issue_we    = we;
    sb_if.issue_dst   = dst;
    sb_if.issue_lat   = lat;
    sb_if.src_addr    = {s1, s0};
    sb_if.src_used    = used;
  endtask

  task automatic fill_table();
`ifdef SCOREBOARD_FWD_EN
    // back-to-back ALU: addu $2 ; addu $3,$2,$2
    add(0, 0, 1, 1,  2, 1, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 0, 1, 1,  3, 1, 2, 2, 2'b11, 0, 4'h5, 2);
    idle(2); idle(1); idle(0);
    // load-use: lw $4 ; addu $5,$4,$0
    add(0, 0, 1, 1,  4, 2, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 0, 1, 1,  5, 1, 4, 0, 2'b11, 1, 4'h0, 1);
    add(0, 0, 1, 1,  5, 1, 4, 0, 2'b11, 0, 4'h2, 2);
    idle(1); idle(1); idle(0);
    // youngest producer wins: addu $6 ; lw $6 ; use $6
    add(0, 0, 1, 1,  6, 1, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 0, 1, 1,  6, 2, 0, 0, 2'b00, 0, 4'h0, 2);
    add(0, 0, 1, 1,  7, 1, 6, 6, 2'b01, 1, 4'h0, 2);
    add(0, 0, 1, 1,  7, 1, 6, 6, 2'b01, 0, 4'h2, 2);
    idle(1); idle(1); idle(0);
    // hold for 4 cycles over a pending lat-2 match, then hold+flush, then flush
    add(0, 0, 1, 1,  9, 2, 0, 0, 2'b00, 0, 4'h0, 1);
    for (int r = 0; r < 4; r++) add(1, 0, 1, 1, 10, 1, 9, 0, 2'b01, 1, 4'h0, 1);
    add(0, 0, 1, 1, 10, 1, 9, 0, 2'b01, 1, 4'h0, 1);
    add(0, 0, 1, 1, 10, 1, 9, 0, 2'b01, 0, 4'h2, 2);
    add(1, 1, 0, 0,  0, 0, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 1, 1, 1, 11, 1, 0, 0, 2'b00, 0, 4'h0, 0);
    // latency 0 behaves as 1
    add(0, 0, 1, 1, 12, 0, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 0, 1, 0,  0, 1, 12, 0, 2'b01, 0, 4'h1, 1);
    idle(1); idle(0);
`else
    // back-to-back ALU: interlock until $2 leaves S3
    add(0, 0, 1, 1,  2, 1, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 0, 1, 1,  3, 1, 2, 2, 2'b11, 1, 4'h0, 1);
    add(0, 0, 1, 1,  3, 1, 2, 2, 2'b11, 1, 4'h0, 1);
    add(0, 0, 1, 1,  3, 1, 2, 2, 2'b11, 1, 4'h0, 0);
    add(0, 0, 1, 1,  3, 1, 2, 2, 2'b11, 0, 4'h0, 1);
    idle(1); idle(1); idle(0);
    // load-use: three stall cycles, then register file
    add(0, 0, 1, 1,  4, 2, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 0, 1, 1,  5, 1, 4, 0, 2'b11, 1, 4'h0, 1);
    add(0, 0, 1, 1,  5, 1, 4, 0, 2'b11, 1, 4'h0, 1);
    add(0, 0, 1, 1,  5, 1, 4, 0, 2'b11, 1, 4'h0, 0);
    add(0, 0, 1, 1,  5, 1, 4, 0, 2'b11, 0, 4'h0, 1);
    idle(1); idle(1); idle(0);
    // youngest producer: stall until both $6 writers are gone
    add(0, 0, 1, 1,  6, 1, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 0, 1, 1,  6, 2, 0, 0, 2'b00, 0, 4'h0, 2);
    add(0, 0, 1, 1,  7, 1, 6, 6, 2'b01, 1, 4'h0, 2);
    add(0, 0, 1, 1,  7, 1, 6, 6, 2'b01, 1, 4'h0, 1);
    add(0, 0, 1, 1,  7, 1, 6, 6, 2'b01, 1, 4'h0, 0);
    add(0, 0, 1, 1,  7, 1, 6, 6, 2'b01, 0, 4'h0, 1);
    idle(1); idle(1); idle(0);
    // hold for 4 cycles, drain, then hold+flush and flush
    add(0, 0, 1, 1,  9, 2, 0, 0, 2'b00, 0, 4'h0, 1);
    for (int r = 0; r < 4; r++) add(1, 0, 1, 1, 10, 1, 9, 0, 2'b01, 1, 4'h0, 1);
    add(0, 0, 1, 1, 10, 1, 9, 0, 2'b01, 1, 4'h0, 1);
    add(0, 0, 1, 1, 10, 1, 9, 0, 2'b01, 1, 4'h0, 1);
    add(0, 0, 1, 1, 10, 1, 9, 0, 2'b01, 1, 4'h0, 0);
    add(0, 0, 1, 1, 10, 1, 9, 0, 2'b01, 0, 4'h0, 1);
    add(1, 1, 0, 0,  0, 0, 0, 0, 2'b00, 0, 4'h0, 0);
    add(0, 1, 1, 1, 11, 1, 0, 0, 2'b00, 0, 4'h0, 0);
    // latency 0 producer still interlocks
    add(0, 0, 1, 1, 12, 0, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 0, 1, 0,  0, 1, 12, 0, 2'b01, 1, 4'h0, 1);
    add(0, 0, 1, 0,  0, 1, 12, 0, 2'b01, 1, 4'h0, 1);
    add(0, 0, 1, 0,  0, 1, 12, 0, 2'b01, 1, 4'h0, 0);
    add(0, 0, 1, 0,  0, 1, 12, 0, 2'b01, 0, 4'h0, 0);
`endif
    // zero register, issue_valid gating and unused sources (both builds)
    add(0, 0, 1, 1,  0, 1, 0, 0, 2'b11, 0, 4'h0, 0);
    add(0, 0, 1, 0,  0, 1, 0, 0, 2'b11, 0, 4'h0, 0);
    add(0, 0, 1, 1,  8, 2, 0, 0, 2'b00, 0, 4'h0, 1);
    add(0, 0, 0, 0,  0, 1, 8, 8, 2'b11, 0, 4'h0, 1);
    add(0, 0, 1, 0,  0, 1, 8, 8, 2'b00, 0, 4'h0, 1);
    idle(0);
  endtask

  // Main stimulus
  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);
    #12;
    chk("reset.stall",    32'(sb_if.stall),    32'd0);
    chk("reset.fwd_sel",  32'(sb_if.fwd_sel),  32'd0);
    chk("reset.inflight", 32'(sb_if.inflight), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    fill_table();
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      drive(vecs[n].hold, vecs[n].flush, vecs[n].iv, vecs[n].we, vecs[n].dst,
            vecs[n].lat, vecs[n].s0, vecs[n].s1, vecs[n].used);
      #1;
      chk($sformatf("v%0d.stall", n),   32'(sb_if.stall),   32'(vecs[n].e_stall));
      chk($sformatf("v%0d.fwd_sel", n), 32'(sb_if.fwd_sel), 32'(vecs[n].e_fwd));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.inflight", n), 32'(sb_if.inflight), 32'(vecs[n].e_inf));
    end

    // Reset asserted in the middle of a load-use stall
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 2'd2, 5'd0, 5'd0, 2'b00);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 2'd1, 5'd4, 5'd0, 2'b01);
    #1;
    chk("rstmid.pre_stall", 32'(sb_if.stall), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstmid.stall",    32'(sb_if.stall),    32'd0);
    chk("rstmid.fwd_sel",  32'(sb_if.fwd_sel),  32'd0);
    chk("rstmid.inflight", 32'(sb_if.inflight), 32'd0);
    @(posedge clk);
    #1;
    chk("rstmid.held_inflight", 32'(sb_if.inflight), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 2'd1, 5'd0, 5'd0, 2'b00);
    #1;
    chk("rstmid.post_stall", 32'(sb_if.stall), 32'd0);
    @(posedge clk);
    #1;
    chk("rstmid.first_alu_inflight", 32'(sb_if.inflight), 32'd1);

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
